meatsquare_spawner: RTL
=======================

Name: meatsquare_spawner

Overview:
- Downstream consumer of the 7-bit LFSR random source.
- Owns a fixed pool of falling-meatsquare slots. On each frame tick it advances every active slot, detects catches or misses against the player, and uses the random value to decide whether to spawn a new meatsquare and at which column.
- Sits between the random generator and the renderer and score logic; the renderer reads slots through a registered read port.

Parameters:
SLOTS, 4, number of object slots (power of 2, 2..8)
FALL_STEP, 1, rows added to y per frame
Y_CATCH, 110, row at which a catch is tested
Y_MAX, 119, bottom row; reaching it is a miss
PLAYER_W, 16, player width in columns
SPAWN_THRESH, 16, spawn allowed when rand_in < SPAWN_THRESH (7-bit compare)
SPAWN_GAP, 8, minimum frames between spawns

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
enable  in  1  game running; low freezes all objects
rand_in  in  7  random value from LFSR, sampled in SPAWN state
player_x  in  8  left column of player
rd_idx  in  log2(SLOTS)  renderer slot select
rd_valid  out  1  selected slot active (registered)
rd_x  out  8  selected slot column (registered)
rd_y  out  7  selected slot row (registered)
hit_pulse  out  1  one-cycle pulse per catch
miss_pulse  out  1  one-cycle pulse per miss
active_count  out  4  number of active slots
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, active-high): all slots inactive with x=0, y=0; gap counter=0; state IDLE; all outputs 0.
- Read port: rd_* reflect slot[rd_idx] one clock after rd_idx is presented; always live, including while busy.
- FSM IDLE: frame_tick && enable -> UPDATE with slot index i=0. frame_tick while busy or with enable low is ignored (not queued).
- FSM UPDATE: one slot per cycle, i=0..SLOTS-1; after the last slot -> SPAWN. For an active slot:
  - ny = y + FALL_STEP, computed 8-bit, no wrap.
  - Catch: y < Y_CATCH, ny >= Y_CATCH, and player_x <= x <= player_x+PLAYER_W-1 (9-bit sum, no wrap) -> clear active, hit_pulse=1 that cycle.
  - Miss: otherwise, if ny >= Y_MAX -> clear active, miss_pulse=1 that cycle.
  - Otherwise y=ny.
  - Catch has priority over miss in the same step.
  - Inactive slots are untouched.
- FSM SPAWN (1 cycle): spawn if gap==0 && rand_in < SPAWN_THRESH && a free slot exists.
  - Target is the lowest-index free slot: x = rand_in + 16 (range 16..143), y=0, active=1, gap=SPAWN_GAP.
  - If no spawn: gap decrements when nonzero.
  - Then -> IDLE.
- Pool full: spawn suppressed; gap still decrements.
- Slot freed in UPDATE may be reused in the same frame's SPAWN.
- active_count: registered population count of the active bits, updated the cycle after any change.
- Multiple hits or misses in one frame appear as separate single-cycle pulses in distinct UPDATE cycles.
- Frame latency: busy high for exactly SLOTS+1 cycles after an accepted tick.
- enable dropping mid-frame: the current UPDATE/SPAWN sequence completes; later ticks are ignored until enable returns high.
- reset mid-frame: immediate return to reset state; no pulse is emitted.

Optional Feature:
- Macro SPAWNER_SCORE_EN.
- Defined: adds outputs hits [7:0] and misses [7:0], saturating at 255, cleared by reset, incremented on hit_pulse and miss_pulse respectively.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then one frame_tick with rand_in=5, gap=0 -> slot0 active, rd_x=21, rd_y=0, active_count=1, busy high exactly 5 cycles (SLOTS=4).
- Tick with rand_in=16 -> no spawn (threshold is strict); next tick with rand_in=15 spawns at x=31. Following 8 ticks with rand_in=0 -> no spawn; 9th tick spawns.
- Object at x=40, player_x=30 -> after 110 ticks exactly one hit_pulse, slot freed, active_count back to 0.
- Object at x=40, player_x=100 -> no hit at row 110; miss_pulse on the tick where y reaches 119, slot freed.
- Fill all 4 slots, rand_in=0, gap=0 -> no spawn, count stays 4. When slot1 misses, the same frame's SPAWN reuses slot1.
- Assert reset mid-UPDATE -> all rd_valid 0, busy 0, no pulses. With SPAWNER_SCORE_EN, 300 hits -> hits=255.

Source files
------------

// File: rtl/meatsquare_spawner.sv
// Falling-meatsquare object pool.
// On each accepted frame tick the FSM walks every slot once (UPDATE, one
// slot per cycle), then spends one cycle deciding whether to spawn a new
// object from the LFSR value (SPAWN), then returns to IDLE.
// Handshake: frame_tick is a one-cycle request that is taken only in IDLE
// with enable high; busy is the not-ready indication, and a tick that
// arrives while busy (or with enable low) is dropped, never queued.
// Optional build macro: SPAWNER_SCORE_EN adds saturating hits/misses counters.
module meatsquare_spawner #(
    parameter int SLOTS        = 4,
    parameter int FALL_STEP    = 1,
    parameter int Y_CATCH      = 110,
    parameter int Y_MAX        = 119,
    parameter int PLAYER_W     = 16,
    parameter int SPAWN_THRESH = 16,
    parameter int SPAWN_GAP    = 8,
    localparam int IW          = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          enable,
    input  logic [6:0]    rand_in,
    input  logic [7:0]    player_x,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [7:0]    rd_x,
    output logic [6:0]    rd_y,
    output logic          hit_pulse,
    output logic          miss_pulse,
    output logic [3:0]    active_count,
    output logic          busy,
    output logic [1:0]    dbg_state
`ifdef SPAWNER_SCORE_EN
    ,
    output logic [7:0]    hits,
    output logic [7:0]    misses
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_SPAWN  = 2'd2
    } state_t;

    localparam logic [7:0]    LP_FALL    = 8'(FALL_STEP);
    localparam logic [7:0]    LP_Y_CATCH = 8'(Y_CATCH);
    localparam logic [7:0]    LP_Y_MAX   = 8'(Y_MAX);
    localparam logic [8:0]    LP_PW_M1   = 9'(PLAYER_W - 1);
    localparam logic [7:0]    LP_THRESH  = 8'(SPAWN_THRESH);
    localparam logic [7:0]    LP_GAP     = 8'(SPAWN_GAP);
    localparam logic [IW-1:0] LP_LAST    = IW'(SLOTS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [SLOTS-1:0] r_active;
    logic [7:0]      r_x [SLOTS];
    logic [6:0]      r_y [SLOTS];
    logic [7:0]      r_gap;
    logic            r_rd_valid;
    logic [7:0]      r_rd_x;
    logic [6:0]      r_rd_y;
    logic [3:0]      r_count;

    logic            w_cur_act;
    logic [7:0]      w_cur_x;
    logic [6:0]      w_cur_y;
    logic [7:0]      w_ny;
    logic [8:0]      w_px_hi;
    logic            w_in_x;
    logic            w_catch;
    logic            w_miss;
    logic            w_free_found;
    logic [IW-1:0]   w_free_idx;
    logic            w_spawn;
    logic [3:0]      w_pop;

    // Decode of the slot currently being advanced.
    assign w_cur_act = r_active[r_idx];
    assign w_cur_x   = r_x[r_idx];
    assign w_cur_y   = r_y[r_idx];
    assign w_ny      = {1'b0, w_cur_y} + LP_FALL;
    assign w_px_hi   = {1'b0, player_x} + LP_PW_M1;
    assign w_in_x    = ({1'b0, w_cur_x} >= {1'b0, player_x}) && ({1'b0, w_cur_x} <= w_px_hi);
    assign w_catch   = (r_state == S_UPDATE) && w_cur_act &&
                       ({1'b0, w_cur_y} < LP_Y_CATCH) && (w_ny >= LP_Y_CATCH) && w_in_x;
    assign w_miss    = (r_state == S_UPDATE) && w_cur_act && !w_catch && (w_ny >= LP_Y_MAX);
    assign w_spawn   = (r_state == S_SPAWN) && (r_gap == 8'd0) &&
                       ({1'b0, rand_in} < LP_THRESH) && w_free_found;

    assign hit_pulse    = w_catch;
    assign miss_pulse   = w_miss;
    assign dbg_state    = r_state;
    assign rd_valid     = r_rd_valid;
    assign rd_x         = r_rd_x;
    assign rd_y         = r_rd_y;
    assign active_count = r_count;

    // Lowest-index free slot and population count of the active bits.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_pop        = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            w_pop = w_pop + 4'(r_active[i]);
        end
    end

    // FSM next-state and busy decode.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_tick && enable) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy = 1'b1;
                if (r_idx == LP_LAST) begin
                    w_state_nxt = S_SPAWN;
                end
            end
            S_SPAWN: begin
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register and slot walk index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_UPDATE) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_idx <= '0;
            end
        end
    end

    // Slot pool: advance/retire in UPDATE, spawn and gap countdown in SPAWN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active <= '0;
            r_gap    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else if (r_state == S_UPDATE && w_cur_act) begin
            if (w_catch || w_miss) begin
                r_active[r_idx] <= 1'b0;
            end else begin
                r_y[r_idx] <= w_ny[6:0];
            end
        end else if (r_state == S_SPAWN) begin
            if (w_spawn) begin
                r_active[w_free_idx] <= 1'b1;
                r_x[w_free_idx]      <= {1'b0, rand_in} + 8'd16;
                r_y[w_free_idx]      <= '0;
                r_gap                <= LP_GAP;
            end else if (r_gap != 8'd0) begin
                r_gap <= r_gap - 8'd1;
            end
        end
    end

    // Registered renderer read port and population count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_count    <= '0;
        end else begin
            r_rd_valid <= r_active[rd_idx];
            r_rd_x     <= r_x[rd_idx];
            r_rd_y     <= r_y[rd_idx];
            r_count    <= w_pop;
        end
    end

`ifdef SPAWNER_SCORE_EN
    logic [7:0] r_hits;
    logic [7:0] r_misses;

    assign hits   = r_hits;
    assign misses = r_misses;

    // Saturating catch and miss tallies.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (w_catch && r_hits != 8'hFF) begin
                r_hits <= r_hits + 8'd1;
            end
            if (w_miss && r_misses != 8'hFF) begin
                r_misses <= r_misses + 8'd1;
            end
        end
    end
`endif

endmodule
